ysyx_22041211_mem_arbiter: RTL and testbench
============================================

Name: ysyx_22041211_mem_arbiter

Overview:
- Two-requester arbiter that shares the single data memory port between the IFU (instruction fetch, read-only) and the LSU (load/store, read/write).
- Sits between those two units and the data SRAM.
- Grants one request at a time and latches it. Issues it to memory with a valid/ready handshake. Routes the response back to the owner.
- Guards every transaction with a response timeout.

Parameters:
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data width
- TIMEOUT, 255, max cycles from grant to response; 0 disables the timeout

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_LEN  IFU read address
- ifu_resp_valid  out  1  IFU response strobe (1 cycle)
- ifu_resp_err  out  1  IFU response timed out
- ifu_rdata  out  DATA_LEN  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_LEN  LSU address
- lsu_wen  in  1  1=store, 0=load
- lsu_wdata  in  DATA_LEN  store data
- lsu_wmask  in  8  byte mask (MEM_MASK_8/16/32 encodings)
- lsu_resp_valid  out  1  LSU response strobe (1 cycle)
- lsu_resp_err  out  1  LSU response timed out
- lsu_rdata  out  DATA_LEN  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_LEN  latched address
- mem_wen  out  1  latched write enable (IFU grant forces 0)
- mem_wdata  out  DATA_LEN  latched write data (0 on IFU grant)
- mem_wmask  out  8  latched mask (IFU grant drives MEM_MASK_32)
- mem_resp_valid  in  1  memory response (1 cycle)
- mem_rdata  in  DATA_LEN  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, last_grant=LSU (IFU wins the first conflict), timeout counter=0.
  - Latched request=0.
  - All outputs 0 after reset.
- State IDLE:
  - Arbitrate combinationally.
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant (round-robin).
  - The granted requester's req_ready=1 in the same cycle; the other's is 0.
  - No valid requester: both readies are 0.
  - On handshake (valid&&ready):
    - latch addr/wen/wdata/wmask and owner;
    - last_grant<=owner;
    - counter<=0;
    - go to REQ.
- State REQ:
  - mem_req_valid=1, payload from latches, held stable until mem_req_ready.
  - mem_req_ready=1: go to RESP.
- State RESP:
  - Wait for mem_resp_valid.
  - On mem_resp_valid: owner's resp_valid=1 and rdata=mem_rdata combinationally that cycle, resp_err=0; go to IDLE.
  - Store responses also pulse resp_valid; rdata is don't-care.
- Readiness: req_ready is 0 in every state other than IDLE. At most one transaction is outstanding.
- Minimum occupancy: grant → REQ → RESP → IDLE is 3 cycles minimum with a 0-wait memory. The next grant is possible in the cycle after the response.
- Memory contract: mem_resp_valid is sampled only in RESP. A response coinciding with mem_req_ready is not supported. A stray mem_resp_valid in IDLE/REQ is ignored.
- Timeout (TIMEOUT>0):
  - Counter increments each cycle in REQ/RESP and saturates.
  - When counter==TIMEOUT-1 and no completion that cycle: owner gets resp_valid=1, resp_err=1, rdata=0; mem_req_valid drops; go to IDLE.
  - Completion and timeout in the same cycle: completion wins (err=0).
- Non-owner outputs: resp_valid=0 and rdata=0 for the non-owner at all times.
- Mid-operation reset: abandons the transaction immediately, with no response to either requester. A late memory response after reset is ignored.
- Requester obligations: a requester must hold valid and payload until ready. Dropping valid before ready is legal and cancels that request.

Decomposition:
- Shared define file:
  - state encodings ARB_IDLE=2'b00, ARB_REQ=2'b01, ARB_RESP=2'b10;
  - owner encoding OWNER_IFU=1'b0, OWNER_LSU=1'b1;
  - the existing MEM_MASK_8/16/32 constants.
- Sub-module ysyx_22041211_rr_arb2: a 2-way round-robin grant (inputs req[1:0], last; output one-hot gnt). It is reused by the later AXI crossbar.
- Everything else stays in the top module.

Test Plan:
- IFU only: ifu_req_valid=1, addr=0x8000_0000; memory ready after 2 cycles, response after 3 → expected:
  - ifu_req_ready pulses in cycle 0;
  - mem_addr=0x8000_0000, mem_wen=0, mem_wmask=MEM_MASK_32;
  - ifu_resp_valid 1 cycle with rdata=0x0000_0413;
  - lsu_resp_valid stays 0.
- LSU store: addr=0x8000_1004, wdata=0xDEAD_BEEF, wmask=MEM_MASK_8, wen=1 → expected:
  - memory sees the exact payload, stable across 3 not-ready cycles;
  - lsu_resp_valid pulses once.
- Conflict: both valid from reset, back-to-back → grants IFU, LSU, IFU, LSU; each grant appears the cycle after the previous response.
- Timeout: TIMEOUT=8; memory accepts but never responds → LSU resp_valid=1 and resp_err=1 exactly 8 cycles after grant, rdata=0, busy falls the next cycle.
- Reset mid-RESP: rst=0 for 1 cycle while waiting, then mem_resp_valid pulses → no resp_valid to anyone, busy=0, last_grant reset (IFU wins the next conflict).
- Zero-wait memory: mem_req_ready=1 constantly, response 1 cycle later → 3-cycle transaction; a completion at counter TIMEOUT-1 reports err=0.

Source files
------------

// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | ysyx_22041211_mem_arbiter_pkg: shared encodings for mem arbiter  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package ysyx_22041211_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_RESP = 2'b10
  } arb_state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  localparam logic [7:0] MEM_MASK_8  = 8'h01;
  localparam logic [7:0] MEM_MASK_16 = 8'h03;
  localparam logic [7:0] MEM_MASK_32 = 8'h0F;

endpackage

`default_nettype wire

// File: rtl/ysyx_22041211_rr_arb2.sv
// +------------------------------------------------------------------+
// | ysyx_22041211_rr_arb2: 2-way round-robin one-hot grant           |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ysyx_22041211_rr_arb2
  import ysyx_22041211_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Bit index equals owner encoding; on conflict the one not served last wins.
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = (last == OWNER_LSU) ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22041211_mem_arbiter.sv
// +------------------------------------------------------------------+
// | ysyx_22041211_mem_arbiter: IFU/LSU share one memory port         |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ysyx_22041211_mem_arbiter
  import ysyx_22041211_mem_arbiter_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_LEN-1:0] ifu_addr,
  output logic                ifu_resp_valid,
  output logic                ifu_resp_err,
  output logic [DATA_LEN-1:0] ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_LEN-1:0] lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_LEN-1:0] lsu_wdata,
  input  logic [7:0]          lsu_wmask,
  output logic                lsu_resp_valid,
  output logic                lsu_resp_err,
  output logic [DATA_LEN-1:0] lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [7:0]          mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic                busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  arb_state_e          state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [7:0]          wmask_q, wmask_d;

  logic [1:0] gnt;
  logic       done;
  logic       tmo;

  ysyx_22041211_rr_arb2 u_rr_arb2 (
    .req  ({lsu_req_valid, ifu_req_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    done           = 1'b0;
    tmo            = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // Readies are held low while reset is asserted so nothing is accepted then.
        ifu_req_ready = gnt[OWNER_IFU] & rst;
        lsu_req_ready = gnt[OWNER_LSU] & rst;
        if (ifu_req_ready || lsu_req_ready) begin
          state_d = ARB_REQ;
          owner_d = lsu_req_ready;
          last_d  = lsu_req_ready;
          cnt_d   = '0;
          if (lsu_req_ready) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = MEM_MASK_32;
          end
        end
      end
      ARB_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        if (mem_resp_valid) begin
          done    = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (state_q != ARB_IDLE) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if ((TIMEOUT > 0) && (cnt_q == CNT_LAST) && !done) begin
        tmo           = 1'b1;
        mem_req_valid = 1'b0;
        state_d       = ARB_IDLE;
      end
    end

    ifu_resp_valid = (done | tmo) & rst & (owner_q == OWNER_IFU);
    lsu_resp_valid = (done | tmo) & rst & (owner_q == OWNER_LSU);
    ifu_resp_err   = tmo & rst & (owner_q == OWNER_IFU);
    lsu_resp_err   = tmo & rst & (owner_q == OWNER_LSU);
    ifu_rdata      = (done && rst && owner_q == OWNER_IFU) ? mem_rdata : '0;
    lsu_rdata      = (done && rst && owner_q == OWNER_LSU) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= OWNER_LSU;
      owner_q <= OWNER_IFU;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// +------------------------------------------------------------------+
// | tb_ysyx_22041211_mem_arbiter: directed vectors for mem arbiter   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_22041211_mem_arbiter;
  import ysyx_22041211_mem_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ifu_req_valid = 1'b0;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr = 32'h8000_0000;
  logic          ifu_resp_valid;
  logic          ifu_resp_err;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid = 1'b0;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr = 32'h8000_1004;
  logic          lsu_wen = 1'b1;
  logic [DW-1:0] lsu_wdata = 32'hDEAD_BEEF;
  logic [7:0]    lsu_wmask = MEM_MASK_8;
  logic          lsu_resp_valid;
  logic          lsu_resp_err;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wmask;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_rdata = 32'h0;
  logic          busy;

  always #5 clk = ~clk;

  ysyx_22041211_mem_arbiter #(
    .ADDR_LEN (AW),
    .DATA_LEN (DW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_err   (ifu_resp_err),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_err   (lsu_resp_err),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .busy           (busy)
  );

  // in  = {rst, ifu_v, lsu_v, mem_req_ready, mem_resp_valid}
  // out = {ifu_rdy, lsu_rdy, mem_req_valid, busy, ifu_rv, ifu_err, lsu_rv, lsu_err}
  // pl  = expected memory payload: 0 cleared, 1 IFU fetch, 2 LSU store
  typedef struct packed {
    logic [4:0]  in;
    logic [31:0] mrd;
    logic [7:0]  out;
    logic [31:0] rd;
    logic [1:0]  pl;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [4:0] i, input logic [31:0] m,
                              input logic [7:0] o, input logic [31:0] r,
                              input logic [1:0] p);
    vec_t v;
    v.in  = i;
    v.mrd = m;
    v.out = o;
    v.rd  = r;
    v.pl  = p;
    return v;
  endfunction

  function automatic void add(input logic [4:0] i, input logic [31:0] m,
                              input logic [7:0] o, input logic [31:0] r,
                              input logic [1:0] p);
    vecs.push_back(mk(i, m, o, r, p));
  endfunction

  task automatic apply(input vec_t v, input string name, input int idx);
    logic [7:0]  act;
    logic [63:0] rd_act, rd_exp;
    logic [72:0] pl_act, pl_exp;
    @(posedge clk);
    #2;
    {rst, ifu_req_valid, lsu_req_valid, mem_req_ready, mem_resp_valid} = v.in;
    mem_rdata = v.mrd;
    #1;
    act = {ifu_req_ready, lsu_req_ready, mem_req_valid, busy,
           ifu_resp_valid, ifu_resp_err, lsu_resp_valid, lsu_resp_err};
    total++;
    if (act !== v.out) begin
      bad++;
      $display("FAIL %s[%0d] ctrl: got %b want %b", name, idx, act, v.out);
    end
    rd_act = {ifu_rdata, lsu_rdata};
    rd_exp = {(v.out[3] ? v.rd : 32'h0), (v.out[1] ? v.rd : 32'h0)};
    total++;
    if (rd_act !== rd_exp) begin
      bad++;
      $display("FAIL %s[%0d] rdata: got %h want %h", name, idx, rd_act, rd_exp);
    end
    pl_act = {mem_addr, mem_wen, mem_wdata, mem_wmask};
    case (v.pl)
      2'd1:    pl_exp = {32'h8000_0000, 1'b0, 32'h0, MEM_MASK_32};
      2'd2:    pl_exp = {32'h8000_1004, 1'b1, 32'hDEAD_BEEF, MEM_MASK_8};
      default: pl_exp = '0;
    endcase
    total++;
    if (pl_act !== pl_exp) begin
      bad++;
      $display("FAIL %s[%0d] payload: got %h want %h", name, idx, pl_act, pl_exp);
    end
  endtask

  task automatic seq_timeout();
    apply(mk(5'b10100, 32'h0, 8'b0100_0000, 32'h0, 2'd2), "tmo", 0);
    apply(mk(5'b10010, 32'h0, 8'b0011_0000, 32'h0, 2'd2), "tmo", 1);
    for (int k = 2; k < TMO; k++)
      apply(mk(5'b10000, 32'hFFFF_FFFF, 8'b0001_0000, 32'h0, 2'd2), "tmo", k);
    apply(mk(5'b10000, 32'hFFFF_FFFF, 8'b0001_0011, 32'h0, 2'd2), "tmo", TMO);
    apply(mk(5'b10000, 32'h0, 8'b0000_0000, 32'h0, 2'd2), "tmo", TMO + 1);
  endtask

  // Response lands exactly when the counter reaches TIMEOUT-1.
  task automatic seq_late_done();
    apply(mk(5'b11000, 32'h0, 8'b1000_0000, 32'h0, 2'd2), "late", 0);
    for (int k = 1; k < TMO - 1; k++)
      apply(mk(5'b10000, 32'h0, 8'b0011_0000, 32'h0, 2'd1), "late", k);
    apply(mk(5'b10010, 32'h0, 8'b0011_0000, 32'h0, 2'd1), "late", TMO - 1);
    apply(mk(5'b10001, 32'h99, 8'b0001_1000, 32'h99, 2'd1), "late", TMO);
    apply(mk(5'b10000, 32'h0, 8'b0000_0000, 32'h0, 2'd1), "late", TMO + 1);
  endtask

  task automatic seq_reset_mid();
    apply(mk(5'b11000, 32'h0, 8'b1000_0000, 32'h0, 2'd1), "rstmid", 0);
    apply(mk(5'b10010, 32'h0, 8'b0011_0000, 32'h0, 2'd1), "rstmid", 1);
    apply(mk(5'b10000, 32'h0, 8'b0001_0000, 32'h0, 2'd1), "rstmid", 2);
    apply(mk(5'b00000, 32'h0, 8'b0001_0000, 32'h0, 2'd1), "rstmid", 3);
    apply(mk(5'b10001, 32'h77, 8'b0000_0000, 32'h0, 2'd0), "rstmid", 4);
    apply(mk(5'b11100, 32'h0, 8'b1000_0000, 32'h0, 2'd0), "rstmid", 5);
    apply(mk(5'b10010, 32'h0, 8'b0011_0000, 32'h0, 2'd1), "rstmid", 6);
    apply(mk(5'b10001, 32'h88, 8'b0001_1000, 32'h88, 2'd1), "rstmid", 7);
    apply(mk(5'b10000, 32'h0, 8'b0000_0000, 32'h0, 2'd1), "rstmid", 8);
  endtask

  initial begin
    // reset state
    add(5'b00000, 32'h0, 8'b0000_0000, 32'h0, 2'd0);
    // IFU only fetch, stray response while in REQ
    add(5'b11000, 32'h0, 8'b1000_0000, 32'h0, 2'd0);
    add(5'b10000, 32'h0, 8'b0011_0000, 32'h0, 2'd1);
    add(5'b10001, 32'h55, 8'b0011_0000, 32'h0, 2'd1);
    add(5'b10010, 32'h0, 8'b0011_0000, 32'h0, 2'd1);
    add(5'b10000, 32'h0, 8'b0001_0000, 32'h0, 2'd1);
    add(5'b10000, 32'h0, 8'b0001_0000, 32'h0, 2'd1);
    add(5'b10001, 32'h0000_0413, 8'b0001_1000, 32'h0000_0413, 2'd1);
    add(5'b10000, 32'h0, 8'b0000_0000, 32'h0, 2'd1);
    // LSU store with three not-ready cycles
    add(5'b10100, 32'h0, 8'b0100_0000, 32'h0, 2'd1);
    add(5'b10000, 32'h0, 8'b0011_0000, 32'h0, 2'd2);
    add(5'b10000, 32'h0, 8'b0011_0000, 32'h0, 2'd2);
    add(5'b10000, 32'h0, 8'b0011_0000, 32'h0, 2'd2);
    add(5'b10010, 32'h0, 8'b0011_0000, 32'h0, 2'd2);
    add(5'b10001, 32'h1234_5678, 8'b0001_0010, 32'h1234_5678, 2'd2);
    add(5'b10000, 32'h0, 8'b0000_0000, 32'h0, 2'd2);
    // reset, then back-to-back conflicts on a zero-wait memory
    add(5'b00000, 32'h0, 8'b0000_0000, 32'h0, 2'd2);
    add(5'b11100, 32'h0, 8'b1000_0000, 32'h0, 2'd0);
    add(5'b11110, 32'h0, 8'b0011_0000, 32'h0, 2'd1);
    add(5'b11101, 32'hA, 8'b0001_1000, 32'hA, 2'd1);
    add(5'b11100, 32'h0, 8'b0100_0000, 32'h0, 2'd1);
    add(5'b11110, 32'h0, 8'b0011_0000, 32'h0, 2'd2);
    add(5'b11101, 32'hB, 8'b0001_0010, 32'hB, 2'd2);
    add(5'b11100, 32'h0, 8'b1000_0000, 32'h0, 2'd2);
    add(5'b11110, 32'h0, 8'b0011_0000, 32'h0, 2'd1);
    add(5'b11101, 32'hC, 8'b0001_1000, 32'hC, 2'd1);
    add(5'b11100, 32'h0, 8'b0100_0000, 32'h0, 2'd1);
    add(5'b11110, 32'h0, 8'b0011_0000, 32'h0, 2'd2);
    add(5'b11101, 32'hD, 8'b0001_0010, 32'hD, 2'd2);
    // stray response while idle
    add(5'b10001, 32'hFFFF_FFFF, 8'b0000_0000, 32'h0, 2'd2);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "vec", i);

    seq_timeout();
    seq_late_done();
    seq_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
